// File: rtl/mips_pkg.sv
// Shared MIPS (P6 subset) opcode/funct constants and the writeback-side instruction decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;

  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {ADDR_RD, ADDR_RT, ADDR_RA, ADDR_NONE} addr_sel_e;
  typedef enum logic [1:0] {DATA_ALU, DATA_MEM, DATA_PC8, DATA_ZERO} data_sel_e;
  typedef enum logic [1:0] {LD_W, LD_H, LD_B} ld_type_e;

  typedef struct packed {
    addr_sel_e addr_sel;
    data_sel_e data_sel;
    ld_type_e  ld_type;
  } wb_ctrl_t;

  // Anything not listed (stores, branches, jr, mult/div, mthi/mtlo, undefined) never writes the GRF.
  function automatic wb_ctrl_t wb_decode(input logic [5:0] op, input logic [5:0] fn);
    wb_ctrl_t c;
    c = '{addr_sel: ADDR_NONE, data_sel: DATA_ZERO, ld_type: LD_W};
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU, F_MFHI, F_MFLO: begin
            c.addr_sel = ADDR_RD;
            c.data_sel = DATA_ALU;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_ADDI, OP_ANDI, OP_LUI: begin
        c.addr_sel = ADDR_RT;
        c.data_sel = DATA_ALU;
      end
      OP_LW: c = '{addr_sel: ADDR_RT, data_sel: DATA_MEM, ld_type: LD_W};
      OP_LH: c = '{addr_sel: ADDR_RT, data_sel: DATA_MEM, ld_type: LD_H};
      OP_LB: c = '{addr_sel: ADDR_RT, data_sel: DATA_MEM, ld_type: LD_B};
      OP_JAL: begin
        c.addr_sel = ADDR_RA;
        c.data_sel = DATA_PC8;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/w_load_ext.sv
// Selects the addressed byte/halfword of an aligned DM word and sign-extends it.
module w_load_ext
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  ld_type_e          ld_type,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] data
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = word[{offset, 3'b000} +: 8];
    half_s = offset[1] ? word[31:16] : word[15:0];
    case (ld_type)
      LD_H:    data = DATA_W'(half_s);
      LD_B:    data = DATA_W'(byte_s);
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mw_writeback_stage.sv
// M/W pipeline register and writeback datapath: GRF write port, W-stage forwarding source,
// retire counter and last-write trace.
module mw_writeback_stage
  import mips_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                CNT_W    = 32,
  parameter logic [DATA_W-1:0] PC_RESET = 32'h00003000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              M_valid,
  input  logic [DATA_W-1:0] M_instr,
  input  logic [DATA_W-1:0] M_pc,
  input  logic [DATA_W-1:0] M_aluOut,
  input  logic [DATA_W-1:0] M_memData,
  output logic [DATA_W-1:0] W_instr,
  output logic [DATA_W-1:0] W_pc,
  output logic              grf_we,
  output logic [4:0]        grf_addr,
  output logic [DATA_W-1:0] grf_wdata,
  output logic [4:0]        W_fwAddr,
  output logic [DATA_W-1:0] W_fwData,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [DATA_W-1:0] trace_pc,
  output logic [4:0]        trace_addr,
  output logic [DATA_W-1:0] trace_data
);

  logic              vld_p1;
  logic [DATA_W-1:0] instr_p1, pc_p1, alu_p1, mem_p1;
  wb_ctrl_t          ctrl;
  logic [DATA_W-1:0] ld_data, sel_data;
  logic [4:0]        sel_addr;
  logic              leave;
  logic              unused_fields;

  // ---- M -> W register boundary ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= PC_RESET;
      alu_p1   <= '0;
      mem_p1   <= '0;
    end else if (flush) begin
      vld_p1   <= 1'b0;
      instr_p1 <= '0;
      pc_p1    <= M_pc;
      alu_p1   <= '0;
      mem_p1   <= '0;
    end else if (en) begin
      vld_p1   <= M_valid;
      instr_p1 <= M_instr;
      pc_p1    <= M_pc;
      alu_p1   <= M_aluOut;
      mem_p1   <= M_memData;
    end
  end

  // ---- W stage: decode and select (combinational from W registers) ----
  assign ctrl          = wb_decode(instr_p1[31:26], instr_p1[5:0]);
  assign unused_fields = ^{instr_p1[25:21], instr_p1[10:6]};

  w_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .ld_type (ctrl.ld_type),
    .offset  (alu_p1[1:0]),
    .word    (mem_p1),
    .data    (ld_data)
  );

  always_comb begin
    case (ctrl.addr_sel)
      ADDR_RD: sel_addr = instr_p1[15:11];
      ADDR_RT: sel_addr = instr_p1[20:16];
      ADDR_RA: sel_addr = REG_RA;
      default: sel_addr = '0;
    endcase
    case (ctrl.data_sel)
      DATA_ALU: sel_data = alu_p1;
      DATA_MEM: sel_data = ld_data;
      DATA_PC8: sel_data = pc_p1 + DATA_W'(8);
      default:  sel_data = '0;
    endcase
  end

  assign grf_we    = vld_p1 && (ctrl.addr_sel != ADDR_NONE) && (sel_addr != 5'd0);
  assign grf_addr  = grf_we ? sel_addr : 5'd0;
  assign grf_wdata = grf_we ? sel_data : '0;
  assign W_fwAddr  = grf_addr;
  assign W_fwData  = grf_wdata;
  assign W_instr   = instr_p1;
  assign W_pc      = pc_p1;

  // The W instruction leaves (and its GRF write commits) whenever the register advances.
  assign leave = en | flush;

  // ---- retire counter and trace (updated as the W instruction leaves) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt <= '0;
      trace_pc   <= '0;
      trace_addr <= '0;
      trace_data <= '0;
    end else begin
      if (leave && vld_p1) retire_cnt <= retire_cnt + CNT_W'(1);
      if (leave && grf_we) begin
        trace_pc   <= pc_p1;
        trace_addr <= grf_addr;
        trace_data <= grf_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mw_writeback_stage.sv
// Scoreboard bench for mw_writeback_stage: random and directed M-stage traffic against a behavioural W model.
module tb_mw_writeback_stage;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en, flush, M_valid;
  logic [31:0] M_instr, M_pc, M_aluOut, M_memData;
  logic [31:0] W_instr, W_pc, grf_wdata, W_fwData, trace_pc, trace_data;
  logic        grf_we;
  logic [4:0]  grf_addr, W_fwAddr, trace_addr;
  logic [CW-1:0] retire_cnt;

  always #5 clk = ~clk;

  mw_writeback_stage #(.DATA_W(32), .CNT_W(CW), .PC_RESET(32'h00003000)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .M_valid(M_valid),
    .M_instr(M_instr), .M_pc(M_pc), .M_aluOut(M_aluOut), .M_memData(M_memData),
    .W_instr(W_instr), .W_pc(W_pc), .grf_we(grf_we), .grf_addr(grf_addr),
    .grf_wdata(grf_wdata), .W_fwAddr(W_fwAddr), .W_fwData(W_fwData),
    .retire_cnt(retire_cnt), .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] instr, pc, wdata, tpc, tdata;
    logic        we;
    logic [4:0]  addr, taddr;
    int          cnt;
  } exp_t;
  exp_t sbq[$];

  logic [5:0] rfns [0:25] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h10, 6'h11,
                              6'h12, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h20, 6'h21, 6'h22,
                              6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h3f};
  logic [5:0] ops [0:13] = '{6'h03, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h20, 6'h21,
                             6'h23, 6'h28, 6'h29, 6'h2b, 6'h3f};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic        m_v;
  logic [31:0] m_instr, m_pc, m_alu, m_mem, m_tpc, m_tdata;
  logic [4:0]  m_taddr;
  int          m_cnt;

  localparam int K_NONE = 0, K_ALU = 1, K_IMM = 2, K_LW = 3, K_LH = 4, K_LB = 5, K_JAL = 6;

  function automatic int kind_of(input logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    if (op == 6'h00)
      return (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27],
                         6'h2a, 6'h2b, 6'h10, 6'h12}) ? K_ALU : K_NONE;
    if (op inside {6'h08, 6'h0c, 6'h0d, 6'h0f}) return K_IMM;
    if (op == 6'h23) return K_LW;
    if (op == 6'h21) return K_LH;
    if (op == 6'h20) return K_LB;
    if (op == 6'h03) return K_JAL;
    return K_NONE;
  endfunction

  task automatic model_wb(output logic we, output logic [4:0] a, output logic [31:0] d);
    int k;
    logic [31:0] part;
    k = kind_of(m_instr);
    a = 5'd0;
    d = 32'd0;
    case (k)
      K_ALU: begin a = m_instr[15:11]; d = m_alu; end
      K_IMM: begin a = m_instr[20:16]; d = m_alu; end
      K_LW:  begin a = m_instr[20:16]; d = m_mem; end
      K_LH: begin
        a = m_instr[20:16];
        part = m_alu[1] ? (m_mem >> 16) : (m_mem & 32'hFFFF);
        d = part[15] ? (part | 32'hFFFF0000) : part;
      end
      K_LB: begin
        a = m_instr[20:16];
        part = (m_mem >> (8 * m_alu[1:0])) & 32'hFF;
        d = part[7] ? (part | 32'hFFFFFF00) : part;
      end
      K_JAL: begin a = 5'd31; d = m_pc + 32'd8; end
      default: ;
    endcase
    we = m_v && (k != K_NONE) && (a != 5'd0);
    if (!we) begin a = 5'd0; d = 32'd0; end
  endtask

  task automatic model_reset();
    m_v = 1'b0; m_instr = '0; m_pc = 32'h00003000; m_alu = '0; m_mem = '0;
    m_cnt = 0; m_tpc = '0; m_taddr = '0; m_tdata = '0;
  endtask

  task automatic model_edge();
    logic we; logic [4:0] a; logic [31:0] d;
    model_wb(we, a, d);
    if (m_v && (en || flush)) m_cnt = (m_cnt + 1) % (1 << CW);
    if ((en || flush) && we) begin m_tpc = m_pc; m_taddr = a; m_tdata = d; end
    if (flush) begin
      m_v = 1'b0; m_instr = '0; m_pc = M_pc; m_alu = '0; m_mem = '0;
    end else if (en) begin
      m_v = M_valid; m_instr = M_instr; m_pc = M_pc; m_alu = M_aluOut; m_mem = M_memData;
    end
  endtask

  task automatic push_expected();
    exp_t e;
    model_wb(e.we, e.addr, e.wdata);
    e.instr = m_instr; e.pc = m_pc; e.cnt = m_cnt;
    e.tpc = m_tpc; e.taddr = m_taddr; e.tdata = m_tdata;
    sbq.push_back(e);
  endtask

  task automatic step(input logic e, input logic f, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] mem);
    en = e; flush = f; M_valid = v; M_instr = ins; M_pc = pc; M_aluOut = alu; M_memData = mem;
    @(posedge clk);
    #1;
    model_edge();
    push_expected();
  endtask

  function automatic logic [31:0] rand_ins();
    logic [31:0] r;
    r = $urandom();
    if (r[31]) return {6'h00, r[25:6], rfns[$urandom_range(0, 25)]};
    return {ops[$urandom_range(0, 13)], r[25:0]};
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("W_instr", W_instr, e.instr);
        chk("W_pc", W_pc, e.pc);
        chk("grf_we", {31'd0, grf_we}, {31'd0, e.we});
        chk("grf_addr", {27'd0, grf_addr}, {27'd0, e.addr});
        chk("grf_wdata", grf_wdata, e.wdata);
        chk("W_fwAddr", {27'd0, W_fwAddr}, {27'd0, e.addr});
        chk("W_fwData", W_fwData, e.wdata);
        chk("retire_cnt", 32'(retire_cnt), 32'(e.cnt));
        chk("trace_pc", trace_pc, e.tpc);
        chk("trace_addr", {27'd0, trace_addr}, {27'd0, e.taddr});
        chk("trace_data", trace_data, e.tdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    en = 0; flush = 0; M_valid = 0; M_instr = '0; M_pc = '0; M_aluOut = '0; M_memData = '0;
    model_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_W_pc", W_pc, 32'h00003000);
    chk("rst_W_instr", W_instr, 32'd0);
    chk("rst_grf_we", {31'd0, grf_we}, 32'd0);
    chk("rst_cnt", 32'(retire_cnt), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // add $3,$1,$2 in W, then asynchronous reset between edges
    step(1, 0, 1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h00003000, 32'h00000055, 32'd0);
    chk("add_we", {31'd0, grf_we}, 32'd1);
    chk("add_addr", {27'd0, grf_addr}, 32'd3);
    step(1, 0, 1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h00003004, 32'h00000066, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_grf_we", {31'd0, grf_we}, 32'd0);
    chk("mid_rst_W_pc", W_pc, 32'h00003000);
    chk("mid_rst_cnt", 32'(retire_cnt), 32'd0);
    chk("mid_rst_trace_pc", trace_pc, 32'd0);
    chk("mid_rst_trace_data", trace_data, 32'd0);
    model_reset();
    #1 reset = 1'b1;

    // load extension
    step(1, 0, 1, {6'h20, 5'd1, 5'd5, 16'd3}, 32'h00003000, 32'h00000003, 32'h80FF1234);
    chk("lb_b3", grf_wdata, 32'hFFFFFF80);
    step(1, 0, 1, {6'h21, 5'd1, 5'd6, 16'd1}, 32'h00003004, 32'h00000001, 32'h1234ABCD);
    chk("lh_lo", grf_wdata, 32'hFFFFABCD);
    step(1, 0, 1, {6'h23, 5'd1, 5'd7, 16'd0}, 32'h00003008, 32'h00000000, 32'h1234ABCD);
    chk("lw", grf_wdata, 32'h1234ABCD);

    // jal, then trace after the following edge
    step(1, 0, 1, {6'h03, 26'h0000C01}, 32'h00003004, 32'h0, 32'h0);
    chk("jal_addr", {27'd0, grf_addr}, 32'd31);
    chk("jal_data", grf_wdata, 32'h0000300C);
    step(1, 0, 1, 32'd0, 32'h00003008, 32'h0, 32'h0);
    chk("jal_trace_pc", trace_pc, 32'h00003004);

    // write to $0 and store suppressed
    step(1, 0, 1, {6'h0d, 5'd1, 5'd0, 16'd5}, 32'h0000300C, 32'h5, 32'h0);
    chk("ori0_we", {31'd0, grf_we}, 32'd0);
    chk("ori0_fwaddr", {27'd0, W_fwAddr}, 32'd0);
    step(1, 0, 1, {6'h2b, 5'd1, 5'd2, 16'd4}, 32'h00003010, 32'h4, 32'h0);
    chk("sw_we", {31'd0, grf_we}, 32'd0);
    chk("sw_trace_unch", trace_pc, 32'h00003004);

    // flush overrides en; then stall
    step(1, 1, 1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h00003014, 32'h77, 32'h0);
    chk("flush_instr", W_instr, 32'd0);
    chk("flush_we", {31'd0, grf_we}, 32'd0);
    step(1, 0, 1, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'h00003018, 32'h88, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, rand_ins(), $urandom(), $urandom(), $urandom());
      chk("stall_wdata", grf_wdata, 32'h00000088);
    end

    // 16 consecutive valid instructions: counter wraps
    for (int i = 0; i < 16; i++)
      step(1, 0, 1, rand_ins(), $urandom(), $urandom(), $urandom());

    // random traffic
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 4) != 0,
           rand_ins(), $urandom(), $urandom(), $urandom());

    @(negedge clk);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
